// File: rtl/mux10_if.sv
// Bus bundle for the 10-way registered selector: ten data sources, select, enable, result.
// The parity signal exists only when MUX10_PARITY_EN is defined.
`timescale 1ns/1ps
interface mux10_if #(
  parameter int unsigned WIDTH = 16
);
  logic             en;
  logic [WIDTH-1:0] d0, d1, d2, d3, d4, d5, d6, d7, d8, d9;
  logic [3:0]       s;
  logic [WIDTH-1:0] y;
  logic             sel_err;
`ifdef MUX10_PARITY_EN
  logic             parity;

  modport master (
    output en, d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, s,
    input  y, sel_err, parity
  );
  modport slave (
    input  en, d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, s,
    output y, sel_err, parity
  );
`else
  modport master (
    output en, d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, s,
    input  y, sel_err
  );
  modport slave (
    input  en, d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, s,
    output y, sel_err
  );
`endif
endinterface

// File: rtl/mux10.sv
// 10-way WIDTH-bit selector with registered output and out-of-range flag.
// Optional registered even parity of y when MUX10_PARITY_EN is defined.
`timescale 1ns/1ps
module mux10 #(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] FILL_VAL = '0
) (
  input  logic   clk,
  input  logic   rst,
  mux10_if.slave bus
);

  logic [WIDTH-1:0] y_d, y_q;
  logic             sel_err_d, sel_err_q;

  // Plain case with a default: an X/Z select falls through to the fill path in 4-state sims.
  always_comb begin
    y_d       = FILL_VAL;
    sel_err_d = 1'b0;
    case (bus.s)
      4'd0:    y_d = bus.d0;
      4'd1:    y_d = bus.d1;
      4'd2:    y_d = bus.d2;
      4'd3:    y_d = bus.d3;
      4'd4:    y_d = bus.d4;
      4'd5:    y_d = bus.d5;
      4'd6:    y_d = bus.d6;
      4'd7:    y_d = bus.d7;
      4'd8:    y_d = bus.d8;
      4'd9:    y_d = bus.d9;
      default: begin
        y_d       = FILL_VAL;
        sel_err_d = 1'b1;
      end
    endcase
  end

  // Reset value is zero, deliberately not FILL_VAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= '0;
      sel_err_q <= 1'b0;
    end else if (bus.en) begin
      y_q       <= y_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.sel_err = sel_err_q;

`ifdef MUX10_PARITY_EN
  logic parity_q;

  // Computed from the next y so parity always matches the registered word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (bus.en) begin
      parity_q <= ^y_d;
    end
  end

  assign bus.parity = parity_q;
`endif

endmodule

// File: tb/tb_mux10.sv
// Directed self-checking bench for mux10: sweep, out-of-range, enable hold, async reset,
// and parity when MUX10_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_mux10;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mux10_if #(.WIDTH(16)) bus ();

  mux10 #(.WIDTH(16), .FILL_VAL(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_y [10];

  initial begin
    total = 0;
    bad   = 0;
    exp_y = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E,
              16'h000F, 16'h0001, 16'h0002, 16'h0003, 16'h0004};

    rst    = 1'b1;
    bus.en = 1'b1;
    bus.s  = 4'd4;
    bus.d0 = 16'h000A; bus.d1 = 16'h000B; bus.d2 = 16'h000C; bus.d3 = 16'h000D;
    bus.d4 = 16'h000E; bus.d5 = 16'h000F; bus.d6 = 16'h0001; bus.d7 = 16'h0002;
    bus.d8 = 16'h0003; bus.d9 = 16'h0004;

    // Reset held across clock edges with en=1 must keep outputs at zero.
    #3;
    chk("reset_y", bus.y, 16'h0000);
    chk("reset_err", {15'b0, bus.sel_err}, 16'h0000);
`ifdef MUX10_PARITY_EN
    chk("reset_par", {15'b0, bus.parity}, 16'h0000);
`endif
    tick();
    tick();
    chk("reset_hold_y", bus.y, 16'h0000);
    #2 rst = 1'b0;

    // Select sweep 0..9
    for (int k = 0; k < 10; k++) begin
      bus.s = 4'(k);
      tick();
      chk($sformatf("sweep_y_s%0d", k), bus.y, exp_y[k]);
      chk($sformatf("sweep_err_s%0d", k), {15'b0, bus.sel_err}, 16'h0000);
`ifdef MUX10_PARITY_EN
      if (k == 0) chk("par_s0", {15'b0, bus.parity}, 16'h0000);
      if (k == 1) chk("par_s1", {15'b0, bus.parity}, 16'h0001);
      if (k == 6) chk("par_s6", {15'b0, bus.parity}, 16'h0001);
`endif
    end

    // Out-of-range selects
    bus.s = 4'hA;
    tick();
    chk("oor_a_y", bus.y, 16'h0000);
    chk("oor_a_err", {15'b0, bus.sel_err}, 16'h0001);
    bus.s = 4'hF;
    tick();
    chk("oor_f_y", bus.y, 16'h0000);
    chk("oor_f_err", {15'b0, bus.sel_err}, 16'h0001);
`ifdef MUX10_PARITY_EN
    chk("par_sf", {15'b0, bus.parity}, 16'h0000);
`endif
    bus.s = 4'd3;
    tick();
    chk("back_s3_y", bus.y, 16'h000D);
    chk("back_s3_err", {15'b0, bus.sel_err}, 16'h0000);

    // Enable hold
    bus.s = 4'd5;
    tick();
    chk("hold_cap_y", bus.y, 16'h000F);
    bus.en = 1'b0;
    bus.s  = 4'd0;
    bus.d5 = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("hold_y_c%0d", c), bus.y, 16'h000F);
    end
    bus.en = 1'b1;
    tick();
    chk("hold_release_y", bus.y, 16'h000A);

    // Async reset mid-cycle from y=0004
    bus.s = 4'd9;
    tick();
    chk("pre_rst_y", bus.y, 16'h0004);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_y", bus.y, 16'h0000);
    chk("async_rst_err", {15'b0, bus.sel_err}, 16'h0000);
    #1 rst = 1'b0;
    bus.s = 4'd1;
    tick();
    chk("post_rst_y", bus.y, 16'h000B);

    // Async reset also clears a set error flag
    bus.s = 4'hC;
    tick();
    chk("pre_rst2_err", {15'b0, bus.sel_err}, 16'h0001);
    #2 rst = 1'b1;
    #1;
    chk("async_rst2_err", {15'b0, bus.sel_err}, 16'h0000);
    #1 rst = 1'b0;
    bus.s = 4'd7;
    tick();
    chk("post_rst2_y", bus.y, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
